// File: rtl/stereo_serializer_pkg.sv
// Shared constants and state type for the I2S stereo serializer.
package stereo_serializer_pkg;

    localparam int unsigned AUDIO_WIDTH      = 16;
    localparam int unsigned FRAME_SLOTS      = 2 * AUDIO_WIDTH;
    localparam int unsigned DEFAULT_BCLK_DIV = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/stereo_serializer_if.sv
// Sample hand-off bus between the conditioner (master) and the serializer (slave).
interface stereo_serializer_if
    import stereo_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = AUDIO_WIDTH
);

    logic [WIDTH-1:0] sample_l;
    logic [WIDTH-1:0] sample_r;
    logic             new_sample;
    logic             ready;

    modport master (
        output sample_l,
        output sample_r,
        output new_sample,
        input  ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  new_sample,
        output ready
    );

endinterface

// File: rtl/stereo_serializer_bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles; fall_tick marks the cycle bclk falls.
module stereo_serializer_bclk_gen
    import stereo_serializer_pkg::*;
#(
    parameter int unsigned BCLK_DIV = DEFAULT_BCLK_DIV
) (
    input  logic clk,
    input  logic clear,
    output logic bclk,
    output logic fall_tick
);

    localparam int unsigned          DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             bclk_q;
    logic             terminal;

    assign terminal = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (terminal) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // Combinational so the top updates its slot state on the same edge bclk falls.
    assign fall_tick = terminal & bclk_q & ~clear;
    assign bclk      = bclk_q;

endmodule

// File: rtl/stereo_serializer.sv
// Double-buffered I2S stereo serializer: holding register + 2*WIDTH-slot frame shifter.
module stereo_serializer
    import stereo_serializer_pkg::*;
#(
    parameter int unsigned WIDTH    = AUDIO_WIDTH,
    parameter int unsigned BCLK_DIV = DEFAULT_BCLK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    stereo_serializer_if.slave  bus,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun,
    output logic                overrun
);

    localparam int unsigned      SLOTS     = 2 * WIDTH;
    localparam int unsigned      SLOT_W    = $clog2(SLOTS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(WIDTH);

    state_t state_q, state_d;

    logic [SLOTS-1:0]  hold_q;
    logic [SLOTS-1:0]  shift_q;
    logic [SLOTS-1:0]  shift_rot;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_next;
    logic              ready_q;
    logic              prev_lsb_q;
    logic              stopping_q;
    logic              sdata_q;
    logic              lrclk_q;
    logic              underrun_q;
    logic              overrun_q;

    logic gen_clear;
    logic fall_tick;
    logic accept;
    logic start;
    logic advance;
    logic boundary;
    logic halt;

    assign gen_clear = reset | (state_q == IDLE);

    stereo_serializer_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .clear     (gen_clear),
        .bclk      (bclk),
        .fall_tick (fall_tick)
    );

    assign accept    = bus.new_sample & ready_q;
    assign slot_next = slot_q + 1'b1;

    // Rotating instead of shifting: after SLOTS-1 rotations the MSB holds F[0], and one
    // more rotation restores F, so an underrun repeat needs no separate frame copy.
    assign shift_rot = {shift_q[SLOTS-2:0], shift_q[SLOTS-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        advance  = 1'b0;
        boundary = 1'b0;
        halt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !ready_q) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (fall_tick) begin
                    if (stopping_q) begin
                        state_d = IDLE;
                        halt    = 1'b1;
                    end else if (slot_q == SLOT_LAST) begin
                        boundary = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            shift_q    <= '0;
            slot_q     <= '0;
            ready_q    <= 1'b1;
            prev_lsb_q <= 1'b0;
            stopping_q <= 1'b0;
            sdata_q    <= 1'b0;
            lrclk_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            overrun_q  <= bus.new_sample & ~ready_q;

            if (accept) begin
                hold_q  <= {bus.sample_l, bus.sample_r};
                ready_q <= 1'b0;
            end

            if (start) begin
                shift_q    <= hold_q;
                ready_q    <= 1'b1;
                slot_q     <= '0;
                prev_lsb_q <= 1'b0;
                stopping_q <= 1'b0;
                sdata_q    <= 1'b0;
                lrclk_q    <= 1'b0;
            end

            if (advance) begin
                slot_q  <= slot_next;
                shift_q <= shift_rot;
                sdata_q <= shift_q[SLOTS-1];
                lrclk_q <= (slot_next >= SLOT_HALF);
            end

            if (boundary) begin
                slot_q     <= '0;
                lrclk_q    <= 1'b0;
                prev_lsb_q <= shift_q[SLOTS-1];
                if (!enable) begin
                    stopping_q <= 1'b1;
                    shift_q    <= shift_rot;
                end else if (!ready_q) begin
                    shift_q <= hold_q;
                    ready_q <= 1'b1;
                end else begin
                    shift_q    <= shift_rot;
                    underrun_q <= 1'b1;
                end
            end

            if (halt) begin
                slot_q     <= '0;
                stopping_q <= 1'b0;
                sdata_q    <= 1'b0;
                lrclk_q    <= 1'b0;
            end
        end
    end

    // Slot 0 carries the previous frame's last right-channel bit (I2S one-bit delay).
    assign sdata     = (state_q == RUN && slot_q == '0) ? prev_lsb_q : sdata_q;
    assign lrclk     = lrclk_q;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;
    assign bus.ready = ready_q;

endmodule
